// File: rtl/link_pkg.sv
// ---------------------------------------------------------------------------
// link_pkg : shared OS-link packet constants, tx state encoding and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package link_pkg;

  localparam int DATA_PKT_BITS = 11;
  localparam int ACK_PKT_BITS  = 2;

  // Patterns are LSB first on the wire: ack = 1,0 ; data header = 1,1
  localparam logic [1:0] ACK_PATTERN = 2'b01;
  localparam logic [1:0] DATA_START  = 2'b11;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  function automatic logic [DATA_PKT_BITS-1:0] data_pattern(input logic [7:0] d);
    return {1'b0, d, DATA_START};
  endfunction

endpackage

`default_nettype wire

// File: rtl/link_bit_timer.sv
// ---------------------------------------------------------------------------
// link_bit_timer : CLK_DIV divider, o_tick on the last clock of each bit period
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module link_bit_timer #(
  parameter int CLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(CLK_DIV - 1));
  assign o_tick = i_en && w_last;

  // Held at zero while disabled so every packet starts on a fresh period
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/os_link_tx.sv
// ---------------------------------------------------------------------------
// os_link_tx : OS-link serial transmitter with stop-and-wait ack handling
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module os_link_tx
  import link_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int ACK_TIMEOUT = 65536
) (
  input  logic       io_clk,
  input  logic       io_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ack_req,
  input  logic       ack_in,
  output logic       link_out,
  output logic       busy,
  output logic       tx_done,
  output logic       ack_ovf,
  output logic       ack_timeout
);

  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  tx_state_e                r_state;
  logic [DATA_PKT_BITS-1:0] r_shift;
  logic [3:0]               r_bits;
  logic                     r_is_data;
  logic                     r_ready_en;
  logic                     r_outstanding;
  logic                     r_ack_pending;
  logic                     r_ack_ovf;
  logic                     r_tx_done;
  logic                     r_ack_timeout;
  logic                     r_to_run;
  logic [TW-1:0]            r_to_cnt;

  logic w_tick;
  logic w_accept;
  logic w_ack_start;
  logic w_pkt_end;
  logic w_remote_ack;
  logic w_to_hit;

  link_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .i_clk  (io_clk),
    .i_rst  (io_rst),
    .i_en   (r_state == TX_SEND),
    .o_tick (w_tick)
  );

  assign tx_ready     = r_ready_en && (r_state == TX_IDLE) && !r_outstanding && !r_ack_pending;
  assign w_accept     = tx_valid && tx_ready;
  assign w_ack_start  = (r_state == TX_IDLE) && r_ack_pending;
  assign w_pkt_end    = (r_state == TX_SEND) && w_tick && (r_bits == 4'd1);
  assign w_remote_ack = ack_in && r_outstanding;
  assign w_to_hit     = r_to_run && (r_to_cnt == TW'(ACK_TIMEOUT - 1));

  assign link_out    = (r_state == TX_SEND) && r_shift[0];
  assign busy        = (r_state == TX_SEND);
  assign tx_done     = r_tx_done;
  assign ack_ovf     = r_ack_ovf;
  assign ack_timeout = r_ack_timeout;

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_bits    <= '0;
      r_is_data <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_ack_start) begin
            r_shift   <= {{(DATA_PKT_BITS - ACK_PKT_BITS){1'b0}}, ACK_PATTERN};
            r_bits    <= 4'(ACK_PKT_BITS);
            r_is_data <= 1'b0;
            r_state   <= TX_SEND;
          end else if (w_accept) begin
            r_shift   <= data_pattern(tx_data);
            r_bits    <= 4'(DATA_PKT_BITS);
            r_is_data <= 1'b1;
            r_state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            r_bits  <= r_bits - 4'd1;
            if (r_bits == 4'd1) begin
              r_state <= TX_IDLE;
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  // A request arriving in the cycle the pending ack is consumed re-arms it
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_ack_pending <= 1'b0;
      r_ack_ovf     <= 1'b0;
    end else if (ack_req) begin
      if (r_ack_pending && !w_ack_start) begin
        r_ack_ovf <= 1'b1;
      end else begin
        r_ack_pending <= 1'b1;
      end
    end else if (w_ack_start) begin
      r_ack_pending <= 1'b0;
    end
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_ready_en    <= 1'b0;
      r_outstanding <= 1'b0;
      r_tx_done     <= 1'b0;
      r_ack_timeout <= 1'b0;
      r_to_run      <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_tx_done  <= w_remote_ack;

      if (w_accept) begin
        r_outstanding <= 1'b1;
      end else if (w_remote_ack || w_to_hit) begin
        r_outstanding <= 1'b0;
      end

      // Timeout window opens when a data packet finishes with no ack yet seen
      if (w_remote_ack || w_accept) begin
        r_to_run <= 1'b0;
        r_to_cnt <= '0;
      end else if (w_pkt_end && r_is_data && r_outstanding && (ACK_TIMEOUT != 0)) begin
        r_to_run <= 1'b1;
        r_to_cnt <= '0;
      end else if (r_to_run) begin
        if (r_to_cnt != {TW{1'b1}}) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
        if (w_to_hit) begin
          r_to_run      <= 1'b0;
          r_ack_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
